iobuffer_fifo_ctrl: RTL

- Pointer/handshake controller that sits directly upstream of the iobuffer dual-port RAM.
- Turns a valid/ready push stream and a valid/ready pop stream into the RAM's write-enable/address and read-address signals.
- Presents the RAM's registered read data as a first-word-fall-through output with occupancy, full/empty and sticky-overflow status.
- Only one clock: the RAM's wclk and rclk are both tied to `clock` at the instantiation site.

---
 rtl/iobuffer_fifo_ctrl_pkg.sv | 13 +
 rtl/iobuffer_fifo_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/iobuffer_fifo_ctrl_pkg.sv
// Constants and helpers shared between the iobuffer FIFO controller and its dual-port RAM.
// Keeping the default geometry here guarantees both sides agree on the address width.
package iobuffer_fifo_ctrl_pkg;

    localparam int IOBUF_DEPTH = 256;
    localparam int IOBUF_WIDTH = 16;

    // Pointers carry one extra wrap bit so that a full FIFO is distinguishable from an empty one.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/iobuffer_fifo_ctrl.sv
// Pointer and handshake controller for the iobuffer dual-port RAM, presenting the RAM's
// registered read port as a first-word-fall-through stream with level and sticky overflow.
module iobuffer_fifo_ctrl
    import iobuffer_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = IOBUF_DEPTH,
    parameter int WIDTH = IOBUF_WIDTH,
    localparam int ABITS = $clog2(DEPTH),
    localparam int PBITS = ptrWidth(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ABITS:0]   level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [WIDTH-1:0] ram_din,
    output logic             ram_write_en,
    output logic [ABITS-1:0] ram_waddr,
    output logic [ABITS-1:0] ram_raddr,
    input  logic [WIDTH-1:0] ram_dout
);

    logic [PBITS-1:0] r_wptr;
    logic [PBITS-1:0] r_rptr;
    logic             r_outValid;
    logic             r_overflow;

    logic [PBITS-1:0] w_avail;
    logic [PBITS-1:0] w_level;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_fetch;

    // Level counts the word sitting on out_data too, so the held head's RAM slot is never
    // reused while it is still being displayed.
    always_comb begin
        w_avail = r_wptr - r_rptr;
        w_level = w_avail + PBITS'(r_outValid);
        w_full  = (w_level == PBITS'(DEPTH));
        w_push  = in_valid && !w_full;
        w_pop   = r_outValid && out_ready;
        w_fetch = (w_avail != '0) && (!r_outValid || out_ready);
    end

    assign in_ready     = !w_full;
    assign full         = w_full;
    assign empty        = (w_level == '0);
    assign level        = w_level;
    assign overflow     = r_overflow;
    assign out_valid    = r_outValid;
    assign out_data     = ram_dout;
    assign ram_din      = in_data;
    assign ram_write_en = w_push;
    assign ram_waddr    = r_wptr[ABITS-1:0];

    // Without a fetch the previous address is re-read so the registered RAM output holds the head.
    assign ram_raddr = w_fetch ? r_rptr[ABITS-1:0] : (r_rptr[ABITS-1:0] - ABITS'(1));

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_outValid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PBITS'(1);
            end
            if (w_fetch) begin
                r_rptr     <= r_rptr + PBITS'(1);
                r_outValid <= 1'b1;
            end else if (w_pop) begin
                r_outValid <= 1'b0;
            end
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
